uart_fifo_component: RTL

Memory-mapped, parametrised UART peripheral for the SoC bus. Its programmable baud divisor and independent Rx/Tx FIFOs let the CPU burst bytes without polling per character. It also provides sticky error flags, loopback and maskable level interrupts tagged with a component id. It sits on the system bus beside the other memory-mapped components and drives the board serial pins.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_fifo_component.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART peripheral: FSM encodings,
// register addresses and the CONTROL / STATUS bit positions.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic [2:0] ADDR_CONTROL  = 3'd0;
    localparam logic [2:0] ADDR_RX_DATA  = 3'd1;
    localparam logic [2:0] ADDR_TX_DATA  = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_DIV_LO   = 3'd4;
    localparam logic [2:0] ADDR_DIV_HI   = 3'd5;
    localparam logic [2:0] ADDR_RX_COUNT = 3'd6;
    localparam logic [2:0] ADDR_TX_COUNT = 3'd7;

    localparam int CTL_RX_IRQ_EN = 0;
    localparam int CTL_TX_IRQ_EN = 1;
    localparam int CTL_LOOPBACK  = 2;
    localparam int CTL_RX_FLUSH  = 3;
    localparam int CTL_TX_FLUSH  = 4;

    localparam int ST_RX_AVAIL    = 0;
    localparam int ST_RX_FULL     = 1;
    localparam int ST_TX_FULL     = 2;
    localparam int ST_TX_IDLE     = 3;
    localparam int ST_RX_OVERRUN  = 4;
    localparam int ST_FRAME_ERR   = 5;
    localparam int ST_TX_OVERFLOW = 6;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head, occupancy count and
// flush. Pushes into a full FIFO and pops from an empty one are dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush discards everything.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_fifo_component.sv
// Memory-mapped UART: register file, baud-timed Tx/Rx shifters, sticky
// error flags, loopback and a registered, maskable level interrupt.
module uart_fifo_component
    import uart_pkg::*;
#(
    parameter int                   DATA_WIDTH   = 8,
    parameter int                   FIFO_DEPTH   = 16,
    parameter int                   DIV_WIDTH    = 16,
    parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV  = 104,
    parameter logic [2:0]           COMPONENT_ID = 3'b000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cs,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [2:0]            addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  rx_in,
    output logic                  tx_out,
    output logic                  irq,
    output logic [2:0]            irq_id
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic wr_act, rd_act, wr_q, rd_q, wr_stb, rd_end;
    logic [2:0] rd_addr;
    logic [2:0] ctrl;
    logic [DIV_WIDTH-1:0] div_reg, div_eff;
    logic tx_push, tx_flush, rx_flush, rx_pop, st_clr;
    logic rx_ovr, rx_ferr, tx_ovf;
    logic [DATA_WIDTH-1:0] status, rd_mux;

    logic [DATA_WIDTH-1:0] tx_head, rx_head;
    logic [CW-1:0] tx_count, rx_count;
    logic tx_full, tx_empty, rx_full, rx_empty;

    tx_state_t tx_state, tx_state_nxt;
    logic [DIV_WIDTH-1:0] tx_cnt, tx_div;
    logic [2:0] tx_bit;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic tx_pop, tx_tc, tx_idle_st;

    rx_state_t rx_state, rx_state_nxt;
    logic [DIV_WIDTH-1:0] rx_cnt, rx_div;
    logic [2:0] rx_bit;
    logic [DATA_WIDTH-1:0] rx_shift, rx_push_data;
    logic rx_s1, rx_s2, line, line_q, fall, rx_tc, stop_done, rx_push;

    assign irq_id  = COMPONENT_ID;
    assign wr_act  = ~cs & ~wr;
    assign rd_act  = ~cs & ~rd;
    assign wr_stb  = wr_act & ~wr_q;
    assign rd_end  = rd_q & ~rd_act;
    assign div_eff = (div_reg < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : div_reg;

    assign tx_push  = wr_stb & (addr == ADDR_TX_DATA);
    assign tx_flush = wr_stb & (addr == ADDR_CONTROL) & in_data[CTL_TX_FLUSH];
    assign rx_flush = wr_stb & (addr == ADDR_CONTROL) & in_data[CTL_RX_FLUSH];
    assign rx_pop   = rd_end & (rd_addr == ADDR_RX_DATA);
    assign st_clr   = rd_end & (rd_addr == ADDR_STATUS);

    // Track access strobes so writes act on entry and reads act on exit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            rd_addr <= '0;
        end else begin
            wr_q <= wr_act;
            rd_q <= rd_act;
            if (rd_act) rd_addr <= addr;
        end
    end

    // Writable configuration: enables, loopback and baud divisor.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl    <= '0;
            div_reg <= DEFAULT_DIV;
        end else if (wr_stb) begin
            case (addr)
                ADDR_CONTROL: ctrl <= in_data[2:0];
                ADDR_DIV_LO:  div_reg[7:0] <= in_data;
                ADDR_DIV_HI:  div_reg[DIV_WIDTH-1:8] <= in_data[DIV_WIDTH-9:0];
                default:      ctrl <= ctrl;
            endcase
        end
    end

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock(clock), .reset(reset), .push(tx_push), .pop(tx_pop),
        .flush(tx_flush), .push_data(in_data), .head_data(tx_head),
        .count(tx_count), .full(tx_full), .empty(tx_empty)
    );

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock(clock), .reset(reset), .push(rx_push), .pop(rx_pop),
        .flush(rx_flush), .push_data(rx_push_data), .head_data(rx_head),
        .count(rx_count), .full(rx_full), .empty(rx_empty)
    );

    assign tx_tc      = (tx_cnt == '0);
    assign tx_idle_st = tx_empty & (tx_state == TX_IDLE);

    // Tx sequencing; a queued byte follows a stop bit with no idle gap.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_pop       = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop       = 1'b1;
                    tx_state_nxt = TX_START;
                end
            end
            TX_START: if (tx_tc) tx_state_nxt = TX_DATA;
            TX_DATA:  if (tx_tc && tx_bit == 3'd7) tx_state_nxt = TX_STOP;
            TX_STOP: begin
                if (tx_tc) begin
                    if (!tx_empty) begin
                        tx_pop       = 1'b1;
                        tx_state_nxt = TX_START;
                    end else begin
                        tx_state_nxt = TX_IDLE;
                    end
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // Tx state register, bit-period down-counter and shift register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            if (tx_pop) begin
                tx_shift <= tx_head;
                tx_div   <= div_eff;
                tx_cnt   <= div_eff - 1'b1;
                tx_bit   <= '0;
            end else if (tx_state != TX_IDLE) begin
                if (tx_tc) begin
                    tx_cnt <= tx_div - 1'b1;
                    if (tx_state == TX_DATA) begin
                        tx_shift <= {1'b0, tx_shift[DATA_WIDTH-1:1]};
                        tx_bit   <= tx_bit + 1'b1;
                    end
                end else begin
                    tx_cnt <= tx_cnt - 1'b1;
                end
            end
        end
    end

    // Registered line driver keeps tx_out glitch-free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_out <= 1'b1;
        end else begin
            case (tx_state)
                TX_START: tx_out <= 1'b0;
                TX_DATA:  tx_out <= tx_shift[0];
                default:  tx_out <= 1'b1;
            endcase
        end
    end

    // Two-flop synchroniser on the pin plus previous-line for edge detect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_s1  <= 1'b1;
            rx_s2  <= 1'b1;
            line_q <= 1'b1;
        end else begin
            rx_s1  <= rx_in;
            rx_s2  <= rx_s1;
            line_q <= line;
        end
    end

    assign line  = ctrl[CTL_LOOPBACK] ? tx_out : rx_s2;
    assign fall  = line_q & ~line;
    assign rx_tc = (rx_cnt == '0);

    // Rx sequencing; a start bit that is high at mid-bit is rejected.
    always_comb begin
        rx_state_nxt = rx_state;
        stop_done    = 1'b0;
        case (rx_state)
            RX_IDLE:  if (fall) rx_state_nxt = RX_START;
            RX_START: if (rx_tc) rx_state_nxt = line ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tc && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
            RX_STOP: begin
                if (rx_tc) begin
                    stop_done    = 1'b1;
                    rx_state_nxt = RX_IDLE;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // Rx state register, sample counter, shifter and staged FIFO push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_div       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_push      <= 1'b0;
            rx_push_data <= '0;
        end else begin
            rx_state     <= rx_state_nxt;
            rx_push      <= stop_done & line & ~rx_full;
            rx_push_data <= rx_shift;
            if (rx_state == RX_IDLE) begin
                if (fall) begin
                    rx_div <= div_eff;
                    rx_cnt <= (div_eff >> 1) - 1'b1;
                    rx_bit <= '0;
                end
            end else if (rx_tc) begin
                rx_cnt <= rx_div - 1'b1;
                if (rx_state == RX_DATA) begin
                    rx_shift <= {line, rx_shift[DATA_WIDTH-1:1]};
                    rx_bit   <= rx_bit + 1'b1;
                end
            end else begin
                rx_cnt <= rx_cnt - 1'b1;
            end
        end
    end

    // Sticky error flags; a new event beats a same-cycle clear-on-read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_ovr  <= 1'b0;
            rx_ferr <= 1'b0;
            tx_ovf  <= 1'b0;
        end else begin
            rx_ovr  <= (stop_done & line & rx_full) | (rx_ovr & ~st_clr);
            rx_ferr <= (stop_done & ~line) | (rx_ferr & ~st_clr);
            tx_ovf  <= (tx_push & tx_full) | (tx_ovf & ~st_clr);
        end
    end

    // Assemble STATUS and the read-data multiplexer.
    always_comb begin
        status                 = '0;
        status[ST_RX_AVAIL]    = ~rx_empty;
        status[ST_RX_FULL]     = rx_full;
        status[ST_TX_FULL]     = tx_full;
        status[ST_TX_IDLE]     = tx_idle_st;
        status[ST_RX_OVERRUN]  = rx_ovr;
        status[ST_FRAME_ERR]   = rx_ferr;
        status[ST_TX_OVERFLOW] = tx_ovf;
        rd_mux = '0;
        case (addr)
            ADDR_CONTROL:  rd_mux[2:0] = ctrl;
            ADDR_RX_DATA:  rd_mux = rx_head;
            ADDR_STATUS:   rd_mux = status;
            ADDR_DIV_LO:   rd_mux = div_reg[7:0];
            ADDR_DIV_HI:   rd_mux = DATA_WIDTH'(div_reg >> 8);
            ADDR_RX_COUNT: rd_mux = DATA_WIDTH'(rx_count);
            ADDR_TX_COUNT: rd_mux = DATA_WIDTH'(tx_count);
            default:       rd_mux = '0;
        endcase
    end

    // Registered read data and interrupt output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            irq      <= 1'b0;
        end else begin
            out_data <= rd_mux;
            irq      <= (ctrl[CTL_RX_IRQ_EN] & (~rx_empty | rx_ovr | rx_ferr))
                      | (ctrl[CTL_TX_IRQ_EN] & tx_idle_st);
        end
    end

endmodule
